// File: rtl/soc.sv
// MIPS32-subset SoC: three-stage core (IF/ID/EXE) with word-addressed instruction and data memories.
// Full bypass from EXE writeback into ID; control transfers resolve in EXE and squash two slots.
module soc (
    input logic clk,
    input logic reset,
    input logic system_ena
);
    logic [9:0]  imem_idx;
    logic [31:0] imem_rdata;
    logic [9:0]  dmem_idx;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_we;

    if (1) begin : imem_inst
        logic [31:0] inst_array [0:1023];
        assign imem_rdata = inst_array[imem_idx];
    end

    if (1) begin : dmem_inst
        logic [31:0] data_array [0:1023];
        always_ff @(posedge clk) begin
            if (dmem_we) data_array[dmem_idx] <= dmem_wdata;
        end
        assign dmem_rdata = data_array[dmem_idx];
    end

    if (1) begin : core0
        localparam logic [31:0] ResetPc = 32'h0040_0000;

        logic [31:0] pc_q, pc_d;
        logic        started_q, started_d;
        logic [31:0] ifid_instr_q, ifid_instr_d, ifid_pc_q, ifid_pc_d;
        logic [31:0] exe_instr_q, exe_instr_d, exe_pc_q, exe_pc_d;
        logic [31:0] exe_a_q, exe_a_d, exe_b_q, exe_b_d;
        logic [31:0] exe_pc_out;
        logic [31:0] rf_a, rf_b, id_a, id_b;
        logic        wb_en, taken, is_store;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data, target;

        assign imem_idx   = pc_q[11:2];
        assign exe_pc_out = exe_pc_q;

        if (1) begin : gpr_inst
            logic [31:0] array_reg [0:31];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < 32; i++) array_reg[i] <= '0;
                end else if (system_ena && wb_en && wb_addr != 5'd0) begin
                    array_reg[wb_addr] <= wb_data;
                end
            end
            assign rf_a = array_reg[ifid_instr_q[25:21]];
            assign rf_b = array_reg[ifid_instr_q[20:16]];
        end

        // Bypass covers load-use too, since the DMEM read is combinational in EXE.
        assign id_a = (wb_en && wb_addr != 5'd0 && wb_addr == ifid_instr_q[25:21]) ? wb_data : rf_a;
        assign id_b = (wb_en && wb_addr != 5'd0 && wb_addr == ifid_instr_q[20:16]) ? wb_data : rf_b;

        if (1) begin : id_exe_reg_inst
            logic [31:0] exe_instr_out;
            always_ff @(posedge clk) begin
                if (reset) begin
                    exe_instr_q <= '0;
                    exe_pc_q    <= '0;
                    exe_a_q     <= '0;
                    exe_b_q     <= '0;
                end else begin
                    exe_instr_q <= exe_instr_d;
                    exe_pc_q    <= exe_pc_d;
                    exe_a_q     <= exe_a_d;
                    exe_b_q     <= exe_b_d;
                end
            end
            assign exe_instr_out = exe_instr_q;
        end

        logic [5:0]  op, funct;
        logic [4:0]  rt, rd, shamt;
        logic [31:0] simm, zimm, pc4;
        assign op    = exe_instr_q[31:26];
        assign funct = exe_instr_q[5:0];
        assign rt    = exe_instr_q[20:16];
        assign rd    = exe_instr_q[15:11];
        assign shamt = exe_instr_q[10:6];
        assign simm  = {{16{exe_instr_q[15]}}, exe_instr_q[15:0]};
        assign zimm  = {16'd0, exe_instr_q[15:0]};
        assign pc4   = exe_pc_q + 32'd4;

        always_comb begin
            wb_en    = 1'b0;
            wb_addr  = rt;
            wb_data  = '0;
            taken    = 1'b0;
            target   = '0;
            is_store = 1'b0;
            case (op)
                6'h00: begin
                    wb_en   = 1'b1;
                    wb_addr = rd;
                    case (funct)
                        6'h20, 6'h21: wb_data = exe_a_q + exe_b_q;
                        6'h22, 6'h23: wb_data = exe_a_q - exe_b_q;
                        6'h24: wb_data = exe_a_q & exe_b_q;
                        6'h25: wb_data = exe_a_q | exe_b_q;
                        6'h26: wb_data = exe_a_q ^ exe_b_q;
                        6'h27: wb_data = ~(exe_a_q | exe_b_q);
                        6'h2a: wb_data = {31'd0, $signed(exe_a_q) < $signed(exe_b_q)};
                        6'h2b: wb_data = {31'd0, exe_a_q < exe_b_q};
                        6'h00: wb_data = exe_b_q << shamt;
                        6'h02: wb_data = exe_b_q >> shamt;
                        6'h03: wb_data = 32'($signed(exe_b_q) >>> shamt);
                        6'h08: begin
                            wb_en  = 1'b0;
                            taken  = 1'b1;
                            target = exe_a_q;
                        end
                        default: wb_en = 1'b0;
                    endcase
                end
                6'h08, 6'h09: begin wb_en = 1'b1; wb_data = exe_a_q + simm; end
                6'h0c: begin wb_en = 1'b1; wb_data = exe_a_q & zimm; end
                6'h0d: begin wb_en = 1'b1; wb_data = exe_a_q | zimm; end
                6'h0e: begin wb_en = 1'b1; wb_data = exe_a_q ^ zimm; end
                6'h0a: begin wb_en = 1'b1; wb_data = {31'd0, $signed(exe_a_q) < $signed(simm)}; end
                6'h0b: begin wb_en = 1'b1; wb_data = {31'd0, exe_a_q < simm}; end
                6'h0f: begin wb_en = 1'b1; wb_data = {exe_instr_q[15:0], 16'd0}; end
                6'h23: begin wb_en = 1'b1; wb_data = dmem_rdata; end
                6'h2b: is_store = 1'b1;
                6'h04, 6'h05: begin
                    taken  = (exe_a_q == exe_b_q) ^ op[0];
                    target = pc4 + {simm[29:0], 2'b00};
                end
                6'h02, 6'h03: begin
                    taken   = 1'b1;
                    target  = {pc4[31:28], exe_instr_q[25:0], 2'b00};
                    wb_en   = op[0];
                    wb_addr = 5'd31;
                    wb_data = pc4;
                end
                default: ;
            endcase
        end

        assign dmem_idx   = 10'((exe_a_q + simm) >> 2);
        assign dmem_wdata = exe_b_q;
        assign dmem_we    = is_store && system_ena && !reset;

        always_comb begin
            pc_d         = pc_q;
            started_d    = started_q;
            ifid_instr_d = ifid_instr_q;
            ifid_pc_d    = ifid_pc_q;
            exe_instr_d  = exe_instr_q;
            exe_pc_d     = exe_pc_q;
            exe_a_d      = exe_a_q;
            exe_b_d      = exe_b_q;
            if (system_ena) begin
                started_d = 1'b1;
                if (taken) begin
                    pc_d         = target;
                    ifid_instr_d = '0;
                    ifid_pc_d    = '0;
                    exe_instr_d  = '0;
                    exe_pc_d     = '0;
                    exe_a_d      = '0;
                    exe_b_d      = '0;
                end else if (started_q) begin
                    pc_d         = pc_q + 32'd4;
                    ifid_instr_d = imem_rdata;
                    ifid_pc_d    = pc_q;
                    exe_instr_d  = ifid_instr_q;
                    exe_pc_d     = ifid_pc_q;
                    exe_a_d      = id_a;
                    exe_b_d      = id_b;
                end
            end
        end

        // The first edge out of reset only arms fetch, so IF starts one cycle later.
        always_ff @(posedge clk) begin
            if (reset) begin
                pc_q         <= ResetPc;
                started_q    <= 1'b0;
                ifid_instr_q <= '0;
                ifid_pc_q    <= '0;
            end else begin
                pc_q         <= pc_d;
                started_q    <= started_d;
                ifid_instr_q <= ifid_instr_d;
                ifid_pc_q    <= ifid_pc_d;
            end
        end
    end
endmodule

// File: tb/tb_soc.sv
// Directed bench for soc: one preloaded program covering forwarding, memory, branch flush,
// jal/jr and enable freeze, checked against an EXE trace table and a final register table.
module tb_soc;
    logic clk = 1'b0;
    logic reset;
    logic system_ena;

    always #5 clk = ~clk;

    soc dut (
        .clk       (clk),
        .reset     (reset),
        .system_ena(system_ena)
    );

    typedef struct {
        int          e;
        logic [31:0] pc;
        logic [31:0] instr;
    } trace_t;

    typedef struct {
        int          r;
        logic [31:0] val;
    } reg_t;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic freeze(input logic [31:0] pc, input logic [31:0] r6, input logic [31:0] m1);
        system_ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("freeze_exe_pc", dut.core0.exe_pc_out, pc);
            check("freeze_gpr6", dut.core0.gpr_inst.array_reg[6], r6);
            check("freeze_dmem1", dut.dmem_inst.data_array[1], m1);
        end
        system_ena = 1'b1;
    endtask

    initial begin
        logic [31:0] prog [0:22];
        trace_t      trace_tbl [15];
        reg_t        reg_tbl [17];

        prog = '{
            32'h24010005, 32'h24220003, 32'h00411823, 32'h3C041234,
            32'h3C051001, 32'h8CA60008, 32'h24C60001, 32'hACA60004,
            32'h10000002, 32'h24070001, 32'h24070002, 32'h24080009,
            32'h0C100014, 32'h240A0007, 32'h240CFFFF, 32'h000C682B,
            32'h0180702A, 32'h000C7F02, 32'h34108001, 32'h08100013,
            32'h24090003, 32'h03E00008, 32'h24090004
        };
        trace_tbl = '{
            '{1, 32'h0, 32'h0}, '{2, 32'h0, 32'h0},
            '{3, 32'h00400000, 32'h24010005}, '{5, 32'h00400008, 32'h00411823},
            '{7, 32'h00400010, 32'h3C051001}, '{11, 32'h00400020, 32'h10000002},
            '{12, 32'h0, 32'h0}, '{13, 32'h0, 32'h0},
            '{14, 32'h0040002C, 32'h24080009}, '{15, 32'h00400030, 32'h0C100014},
            '{16, 32'h0, 32'h0}, '{18, 32'h00400050, 32'h24090003},
            '{19, 32'h00400054, 32'h03E00008}, '{20, 32'h0, 32'h0},
            '{22, 32'h00400034, 32'h240A0007}
        };
        reg_tbl = '{
            '{0, 32'h0}, '{1, 32'h5}, '{2, 32'h8}, '{3, 32'h3},
            '{4, 32'h12340000}, '{5, 32'h10010000}, '{6, 32'hDEADBEF0}, '{7, 32'h0},
            '{8, 32'h9}, '{9, 32'h3}, '{10, 32'h7}, '{12, 32'hFFFFFFFF},
            '{13, 32'h1}, '{14, 32'h1}, '{15, 32'hF}, '{16, 32'h00008001},
            '{31, 32'h00400034}
        };

        for (int i = 0; i < 1024; i++) dut.imem_inst.inst_array[i] = 32'h0;
        for (int i = 0; i < 23; i++) dut.imem_inst.inst_array[i] = prog[i];
        dut.dmem_inst.data_array[1] = 32'h0;
        dut.dmem_inst.data_array[2] = 32'hDEADBEEF;

        reset      = 1'b1;
        system_ena = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_exe_pc", dut.core0.exe_pc_out, 32'h0);
        check("reset_exe_instr", dut.core0.id_exe_reg_inst.exe_instr_out, 32'h0);
        for (int i = 0; i < 32; i++) check("reset_gpr", dut.core0.gpr_inst.array_reg[i], 32'h0);
        reset = 1'b0;

        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            foreach (trace_tbl[t]) begin
                if (trace_tbl[t].e == e) begin
                    check("trace_exe_pc", dut.core0.exe_pc_out, trace_tbl[t].pc);
                    check("trace_exe_instr", dut.core0.id_exe_reg_inst.exe_instr_out,
                          trace_tbl[t].instr);
                end
            end
            if (e == 2) check("gpr1_zero_after_release", dut.core0.gpr_inst.array_reg[1], 32'h0);
            if (e == 9) freeze(32'h00400018, 32'hDEADBEEF, 32'h0);
            if (e == 10) freeze(32'h0040001C, 32'hDEADBEF0, 32'h0);
            if (e == 11) check("sw_after_freeze", dut.dmem_inst.data_array[1], 32'hDEADBEF0);
        end

        foreach (reg_tbl[t])
            check($sformatf("gpr%0d", reg_tbl[t].r), dut.core0.gpr_inst.array_reg[reg_tbl[t].r],
                  reg_tbl[t].val);
        check("dmem1", dut.dmem_inst.data_array[1], 32'hDEADBEF0);
        check("dmem2", dut.dmem_inst.data_array[2], 32'hDEADBEEF);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
